// File: rtl/ibex_pkg.sv
// Shared types for the LSU response tracker: access size encoding and the
// per-request bookkeeping entry held while a bus response is outstanding.
package ibex_pkg;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    HALF = 2'b01,
    BYTE = 2'b10
  } lsu_req_type_e;

  typedef struct packed {
    logic          we;
    lsu_req_type_e req_type;
    logic          sign_ext;
    logic [1:0]    offset;
    logic          killed;
  } lsu_resp_entry_t;

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Combinational load-data alignment: rotate the bus word so the addressed
// byte lands at bit 0, then extract and extend according to access size.
module ibex_lsu_rdata_align
  import ibex_pkg::*;
(
  input  logic [31:0]   rdata,
  input  lsu_req_type_e req_type,
  input  logic          sign_ext,
  input  logic [1:0]    offset,
  output logic [31:0]   wdata
);

  logic [31:0] rotated;

  always_comb begin
    rotated = rdata;
    case (offset)
      2'd1:    rotated = {rdata[7:0],  rdata[31:8]};
      2'd2:    rotated = {rdata[15:0], rdata[31:16]};
      2'd3:    rotated = {rdata[23:0], rdata[31:24]};
      default: rotated = rdata;
    endcase
  end

  always_comb begin
    wdata = rotated;
    case (req_type)
      HALF:    wdata = {{16{sign_ext & rotated[15]}}, rotated[15:0]};
      BYTE:    wdata = {{24{sign_ext & rotated[7]}}, rotated[7:0]};
      default: wdata = rotated;
    endcase
  end

endmodule

// File: rtl/ibex_lsu_resp_tracker.sv
// Tracks granted data-bus requests in order and turns each bus response into
// a zero-latency writeback response, honouring flushes and flagging misuse.
module ibex_lsu_resp_tracker
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        setback_i,
  input  logic        req_issue_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_type_i,
  input  logic        req_sign_ext_i,
  input  logic [1:0]  req_offset_i,
  output logic        issue_ready_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,
  output logic        rf_we_lsu_o,
  output logic [31:0] rf_wdata_lsu_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [2:0]  DepthCnt = 3'(Depth);

  lsu_resp_entry_t fifo_q [Depth];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [2:0]      count_q;
  logic            perr_q;

  lsu_resp_entry_t head, new_entry;
  logic            empty, full, pop, push, perr_set;
  logic [31:0]     aligned;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  always_comb begin
    empty              = (count_q == 3'd0);
    full               = (count_q >= DepthCnt);
    head               = fifo_q[rptr_q];
    pop                = data_rvalid_i & ~empty;
    push               = req_issue_i & (~full | pop);
    new_entry.we       = req_we_i;
    new_entry.req_type = (req_type_i == 2'b11) ? WORD : lsu_req_type_e'(req_type_i);
    new_entry.sign_ext = req_sign_ext_i;
    new_entry.offset   = req_offset_i;
    new_entry.killed   = 1'b0;
    perr_set           = (data_rvalid_i & empty)
                       | (req_issue_i & full & ~pop)
                       | (req_issue_i & (req_type_i == 2'b11));
  end

  ibex_lsu_rdata_align u_align (
    .rdata    (data_rdata_i),
    .req_type (head.req_type),
    .sign_ext (head.sign_ext),
    .offset   (head.offset),
    .wdata    (aligned)
  );

  // A flush in the response cycle suppresses the response for the head too.
  always_comb begin
    lsu_resp_valid_o = pop & ~head.killed & ~setback_i;
    lsu_resp_err_o   = lsu_resp_valid_o & data_err_i;
    rf_we_lsu_o      = lsu_resp_valid_o & ~head.we & ~data_err_i;
    rf_wdata_lsu_o   = rf_we_lsu_o ? aligned : 32'd0;
    issue_ready_o    = (count_q < DepthCnt);
    outstanding_o    = count_q;
    protocol_err_o   = perr_q;
  end

  // Kill marking precedes the push so a same-cycle push stays live.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= 3'd0;
      perr_q  <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) fifo_q[i] <= '0;
    end else begin
      if (setback_i) begin
        for (int unsigned i = 0; i < Depth; i++) fifo_q[i].killed <= 1'b1;
      end
      if (push) begin
        fifo_q[wptr_q] <= new_entry;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (push && !pop)      count_q <= count_q + 3'd1;
      else if (!push && pop) count_q <= count_q - 3'd1;
      if (perr_set) perr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_lsu_resp_tracker.sv
// Scoreboard bench for ibex_lsu_resp_tracker: a queue-based reference model
// predicts per-cycle status and responses; a monitor compares on the falling edge.
module tb_ibex_lsu_resp_tracker;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        setback_i = 1'b0;
  logic        req_issue_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_type_i = 2'b00;
  logic        req_sign_ext_i = 1'b0;
  logic [1:0]  req_offset_i = 2'b00;
  logic        issue_ready_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = 32'd0;
  logic        data_err_i = 1'b0;
  logic        rf_we_lsu_o;
  logic [31:0] rf_wdata_lsu_o;
  logic        lsu_resp_valid_o;
  logic        lsu_resp_err_o;
  logic [2:0]  outstanding_o;
  logic        protocol_err_o;

  ibex_lsu_resp_tracker #(.Depth(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .setback_i        (setback_i),
    .req_issue_i      (req_issue_i),
    .req_we_i         (req_we_i),
    .req_type_i       (req_type_i),
    .req_sign_ext_i   (req_sign_ext_i),
    .req_offset_i     (req_offset_i),
    .issue_ready_o    (issue_ready_o),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i),
    .data_err_i       (data_err_i),
    .rf_we_lsu_o      (rf_we_lsu_o),
    .rf_wdata_lsu_o   (rf_wdata_lsu_o),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_err_o   (lsu_resp_err_o),
    .outstanding_o    (outstanding_o),
    .protocol_err_o   (protocol_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       we;
    bit [1:0] ty;
    bit       sx;
    bit [1:0] off;
    bit       killed;
  } m_t;

  typedef struct {
    bit        valid;
    bit        err;
    bit        we;
    bit [31:0] wdata;
  } resp_t;

  typedef struct {
    int unsigned outstanding;
    bit          ready;
    bit          perr;
  } stat_t;

  m_t    mq[$];
  bit    model_perr = 1'b0;
  resp_t resp_q[$];
  stat_t stat_q[$];
  bit    mon_en = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] model_load(input bit [31:0] rd, input m_t e);
    bit [63:0] dbl;
    bit [31:0] r;
    dbl = {rd, rd} >> (8 * e.off);
    r = dbl[31:0];
    case (e.ty)
      2'd1:    return e.sx ? {{16{r[15]}}, r[15:0]} : {16'h0, r[15:0]};
      2'd2:    return e.sx ? {{24{r[7]}}, r[7:0]} : {24'h0, r[7:0]};
      default: return r;
    endcase
  endfunction

  // Predict this cycle's outputs from the current inputs, then advance the model.
  task automatic step();
    stat_t s;
    resp_t r;
    bit    popped;
    m_t    e;
    s.outstanding = mq.size();
    s.ready = (mq.size() < DEPTH);
    s.perr = model_perr;
    stat_q.push_back(s);
    popped = 1'b0;
    if (data_rvalid_i) begin
      r = '{valid: 1'b0, err: 1'b0, we: 1'b0, wdata: 32'd0};
      if (mq.size() == 0) begin
        model_perr = 1'b1;
      end else begin
        popped = 1'b1;
        r.valid = !mq[0].killed && !setback_i;
        r.err = r.valid && data_err_i;
        r.we = r.valid && !mq[0].we && !data_err_i;
        r.wdata = r.we ? model_load(data_rdata_i, mq[0]) : 32'd0;
      end
      resp_q.push_back(r);
    end
    if (setback_i) foreach (mq[i]) mq[i].killed = 1'b1;
    if (popped) void'(mq.pop_front());
    if (req_issue_i) begin
      if (req_type_i == 2'b11) model_perr = 1'b1;
      if (mq.size() < DEPTH) begin
        e.we = req_we_i;
        e.ty = (req_type_i == 2'b11) ? 2'b00 : req_type_i;
        e.sx = req_sign_ext_i;
        e.off = req_offset_i;
        e.killed = 1'b0;
        mq.push_back(e);
      end else begin
        model_perr = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit iss, input bit we, input bit [1:0] ty, input bit sx,
                       input bit [1:0] off, input bit rv, input bit [31:0] rd,
                       input bit er, input bit sb);
    @(posedge clk);
    #1;
    req_issue_i = iss;
    req_we_i = we;
    req_type_i = ty;
    req_sign_ext_i = sx;
    req_offset_i = off;
    data_rvalid_i = rv;
    data_rdata_i = rd;
    data_err_i = er;
    setback_i = sb;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 32'd0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_i = 1'b1;
    req_issue_i = 0; data_rvalid_i = 0; setback_i = 0; data_err_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    mq.delete();
    model_perr = 1'b0;
    mon_en = 1'b1;
    step();
  endtask

  // Monitor: status every cycle, response whenever the bus or DUT presents one.
  always @(negedge clk) begin
    if (mon_en) begin
      stat_t s;
      resp_t r;
      if (stat_q.size() == 0) begin
        chk("status_queue_underflow", 32'd1, 32'd0);
      end else begin
        s = stat_q.pop_front();
        chk("outstanding", 32'(outstanding_o), 32'(s.outstanding));
        chk("issue_ready", 32'(issue_ready_o), 32'(s.ready));
        chk("protocol_err", 32'(protocol_err_o), 32'(s.perr));
      end
      if (data_rvalid_i || lsu_resp_valid_o) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_resp_valid", 32'(lsu_resp_valid_o), 32'd0);
        end else begin
          r = resp_q.pop_front();
          chk("resp_valid", 32'(lsu_resp_valid_o), 32'(r.valid));
          chk("resp_err", 32'(lsu_resp_err_o), 32'(r.err));
          chk("rf_we", 32'(rf_we_lsu_o), 32'(r.we));
          chk("rf_wdata", rf_wdata_lsu_o, r.wdata);
        end
      end else begin
        chk("idle_rf_we", 32'(rf_we_lsu_o), 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    idle(1);

    // Byte load, offset 2, sign extended.
    drive(1, 0, 2'b10, 1, 2'd2, 0, 32'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0080_0000, 0, 0);
    idle(1);

    // Back-to-back half then word loads.
    drive(1, 0, 2'b01, 0, 2'd0, 0, 32'd0, 0, 0);
    drive(1, 0, 2'b00, 0, 2'd0, 0, 32'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h1234_ABCD, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
    idle(1);

    // Flush with two loads outstanding; responses are swallowed.
    drive(1, 0, 2'b00, 0, 2'd0, 0, 32'd0, 0, 0);
    drive(1, 0, 2'b01, 1, 2'd2, 0, 32'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 32'd0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 32'h1111_2222, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h3333_4444, 0, 0);
    idle(1);

    // Store with bus error.
    drive(1, 1, 2'b00, 0, 2'd0, 0, 32'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 1, 0);
    idle(1);

    // Flush in the same cycle as a push and a response.
    drive(1, 0, 2'b10, 0, 2'd1, 0, 32'd0, 0, 0);
    drive(1, 0, 2'b10, 0, 2'd3, 1, 32'hA5A5_5A5A, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 32'h8877_6655, 0, 0);
    idle(1);

    // Full FIFO: simultaneous issue and response, then drain and overrun.
    drive(1, 0, 2'b01, 1, 2'd2, 0, 32'd0, 0, 0);
    drive(1, 0, 2'b10, 1, 2'd1, 0, 32'd0, 0, 0);
    drive(1, 0, 2'b00, 0, 2'd0, 1, 32'h8001_7FFF, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0000_8000, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0102_0304, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    idle(3);
    do_reset();

    // Issue while full without a pop is dropped.
    drive(1, 0, 2'b00, 0, 2'd0, 0, 32'd0, 0, 0);
    drive(1, 0, 2'b00, 0, 2'd0, 0, 32'd0, 0, 0);
    drive(1, 0, 2'b10, 0, 2'd0, 0, 32'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0000_0001, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0000_0002, 0, 0);
    idle(1);
    do_reset();

    // Reserved size behaves as word and is flagged.
    drive(1, 0, 2'b11, 1, 2'd2, 0, 32'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h89AB_CDEF, 0, 0);
    idle(1);
    do_reset();

    // Reset with loads outstanding; later responses are protocol errors.
    drive(1, 0, 2'b00, 0, 2'd0, 0, 32'd0, 0, 0);
    drive(1, 0, 2'b00, 0, 2'd0, 0, 32'd0, 0, 0);
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 32'h5555_5555, 0, 0);
    idle(2);
    do_reset();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      bit       iss, rv;
      bit [1:0] ty;
      iss = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < ((mq.size() == 0) ? 3 : 50));
      ty = ($urandom_range(0, 99) < 4) ? 2'b11 : 2'($urandom_range(0, 2));
      drive(iss, 1'($urandom_range(0, 3) == 0), ty, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), rv, $urandom, 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 19) == 0));
      if (n % 150 == 149) do_reset();
    end
    idle(2);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(stat_q.size() + resp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
